// File: rtl/multi_flop_synch_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_flop_synch_edge                                                    |
// | SIZE-channel async-to-dest_clk synchroniser, debounce filter, edge pulse |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module multi_flop_synch_edge #(
  parameter int                SIZE          = 4,
  parameter int                SYNC_STAGES   = 2,
  parameter int                FILTER_CYCLES = 1,
  parameter logic [2*SIZE-1:0] EDGE_MODE     = {SIZE{2'b01}},
  parameter logic [SIZE-1:0]   RESET_VAL     = {SIZE{1'b0}}
) (
  input  logic            dest_clk,
  input  logic            rst,
  input  logic [SIZE-1:0] signal_in,
  output logic [SIZE-1:0] level_out,
  output logic [SIZE-1:0] pulse_out
);

  if (SYNC_STAGES < 2) begin : g_chk_stages
    $error("multi_flop_synch_edge: SYNC_STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_chk_filter
    $error("multi_flop_synch_edge: FILTER_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    logic                   level_q;
    logic                   level_d;

    always_ff @(posedge dest_clk or posedge rst) begin
      if (rst) begin
        sync_r <= {SYNC_STAGES{RESET_VAL[i]}};
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], signal_in[i]};
      end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

    if (FILTER_CYCLES == 1) begin : g_nofilt
      always_ff @(posedge dest_clk or posedge rst) begin
        if (rst) begin
          level_q <= RESET_VAL[i];
        end else begin
          level_q <= sync_q;
        end
      end
    end else begin : g_filt
      localparam int               CNT_W    = $clog2(FILTER_CYCLES);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
      logic [CNT_W-1:0] cnt;

      // cnt counts consecutive cycles that sync_q has disagreed with level_q
      always_ff @(posedge dest_clk or posedge rst) begin
        if (rst) begin
          level_q <= RESET_VAL[i];
          cnt     <= '0;
        end else if (sync_q == level_q) begin
          cnt     <= '0;
        end else if (cnt == CNT_LAST) begin
          level_q <= sync_q;
          cnt     <= '0;
        end else begin
          cnt     <= cnt + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge dest_clk or posedge rst) begin
      if (rst) begin
        level_d <= RESET_VAL[i];
      end else begin
        level_d <= level_q;
      end
    end

    assign level_out[i] = level_q;

    case (EDGE_MODE[2*i +: 2])
      2'b00:   begin : g_level
        assign pulse_out[i] = level_q;
      end
      2'b01:   begin : g_rise
        assign pulse_out[i] = level_q & ~level_d;
      end
      2'b10:   begin : g_fall
        assign pulse_out[i] = ~level_q & level_d;
      end
      default: begin : g_both
        assign pulse_out[i] = level_q ^ level_d;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_flop_synch_edge.sv
`default_nettype none
// Directed and randomised checks of multi_flop_synch_edge across several
// parameter sets; one instance per scenario, shared clock and reset.
module tb_multi_flop_synch_edge;

  logic       dest_clk = 1'b0;
  logic       rst;
  logic [3:0] sig_a, sig_b, sig_c, sig_d, sig_r;
  logic [3:0] lvl_a, pls_a, lvl_b, pls_b, lvl_c, pls_c, lvl_d, pls_d;
  logic [3:0] lvl_r1, pls_r1, lvl_r2, pls_r2;
  logic [3:0] hist [0:2999];
  int         checks = 0;
  int         errors = 0;

  always #5 dest_clk = ~dest_clk;

  multi_flop_synch_edge dut_a (
    .dest_clk(dest_clk), .rst(rst), .signal_in(sig_a), .level_out(lvl_a), .pulse_out(pls_a));

  multi_flop_synch_edge #(.EDGE_MODE(8'b11_10_01_00)) dut_b (
    .dest_clk(dest_clk), .rst(rst), .signal_in(sig_b), .level_out(lvl_b), .pulse_out(pls_b));

  multi_flop_synch_edge #(.SYNC_STAGES(3), .FILTER_CYCLES(4)) dut_c (
    .dest_clk(dest_clk), .rst(rst), .signal_in(sig_c), .level_out(lvl_c), .pulse_out(pls_c));

  multi_flop_synch_edge #(.RESET_VAL(4'b1010)) dut_d (
    .dest_clk(dest_clk), .rst(rst), .signal_in(sig_d), .level_out(lvl_d), .pulse_out(pls_d));

  multi_flop_synch_edge #(.SYNC_STAGES(2), .FILTER_CYCLES(1), .EDGE_MODE(8'b11_10_01_00)) dut_r1 (
    .dest_clk(dest_clk), .rst(rst), .signal_in(sig_r), .level_out(lvl_r1), .pulse_out(pls_r1));

  multi_flop_synch_edge #(.SYNC_STAGES(4), .FILTER_CYCLES(3), .EDGE_MODE(8'b11_10_01_00)) dut_r2 (
    .dest_clk(dest_clk), .rst(rst), .signal_in(sig_r), .level_out(lvl_r2), .pulse_out(pls_r2));

  task automatic tick;
    @(posedge dest_clk);
    #1;
  endtask

  task automatic do_reset;
    sig_a = 4'b0000; sig_b = 4'b0000; sig_c = 4'b0000; sig_d = 4'b1010; sig_r = 4'b0000;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Accepted level at edge n: the last f filter samples all disagree with cur
  function automatic logic [3:0] next_lvl(int n, int s, int f, logic [3:0] cur);
    logic [3:0] r;
    r = cur;
    for (int ch = 0; ch < 4; ch++) begin
      logic all_diff;
      all_diff = 1'b1;
      for (int j = 0; j < f; j++) begin
        int   idx;
        logic v;
        idx = n - s - j;
        v   = (idx < 0) ? 1'b0 : hist[idx][ch];
        if (v == cur[ch]) all_diff = 1'b0;
      end
      if (all_diff) r[ch] = ~cur[ch];
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_pulse(logic [3:0] l, logic [3:0] p);
    return {l[3] ^ p[3], ~l[2] & p[2], l[1] & ~p[1], l[0]};
  endfunction

  task automatic test_reset;
    sig_a = 4'b0000; sig_b = 4'b0000; sig_c = 4'b0000; sig_d = 4'b1010; sig_r = 4'b0000;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (lvl_a !== 4'b0000) begin errors++; $display("FAIL reset_lvl_a got %b exp 0000", lvl_a); end
    checks++; if (pls_a !== 4'b0000) begin errors++; $display("FAIL reset_pls_a got %b exp 0000", pls_a); end
    checks++; if (pls_b !== 4'b0000) begin errors++; $display("FAIL reset_pls_b got %b exp 0000", pls_b); end
    checks++; if (lvl_c !== 4'b0000) begin errors++; $display("FAIL reset_lvl_c got %b exp 0000", lvl_c); end
    checks++; if (lvl_d !== 4'b1010) begin errors++; $display("FAIL reset_lvl_d got %b exp 1010", lvl_d); end
    checks++; if (pls_d !== 4'b0000) begin errors++; $display("FAIL reset_pls_d got %b exp 0000", pls_d); end
    tick();
    tick();
    rst = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++; if (pls_a !== 4'b0000) begin errors++; $display("FAIL release_pls_a t=%0d got %b exp 0000", t, pls_a); end
      checks++; if ({lvl_d, pls_d} !== 8'b1010_0000) begin errors++; $display("FAIL release_d t=%0d got %b/%b exp 1010/0000", t, lvl_d, pls_d); end
    end
  endtask

  task automatic test_basic;
    logic [3:0] el, ep;
    sig_a = 4'b0101;
    for (int t = 1; t <= 5; t++) begin
      tick();
      el = (t >= 3) ? 4'b0101 : 4'b0000;
      ep = (t == 3) ? 4'b0101 : 4'b0000;
      checks++; if (lvl_a !== el) begin errors++; $display("FAIL basic_lvl t=%0d got %b exp %b", t, lvl_a, el); end
      checks++; if (pls_a !== ep) begin errors++; $display("FAIL basic_pls t=%0d got %b exp %b", t, pls_a, ep); end
    end
  endtask

  task automatic test_edge_modes;
    logic [3:0] el, ep;
    sig_b = 4'b1111;
    for (int t = 1; t <= 10; t++) begin
      tick();
      el = (t >= 3) ? 4'b1111 : 4'b0000;
      ep = (t < 3) ? 4'b0000 : (t == 3) ? 4'b1011 : 4'b0001;
      checks++; if ({lvl_b, pls_b} !== {el, ep}) begin errors++; $display("FAIL modes_rise t=%0d got %b/%b exp %b/%b", t, lvl_b, pls_b, el, ep); end
    end
    sig_b = 4'b0000;
    for (int t = 1; t <= 10; t++) begin
      tick();
      el = (t >= 3) ? 4'b0000 : 4'b1111;
      ep = (t < 3) ? 4'b0001 : (t == 3) ? 4'b1100 : 4'b0000;
      checks++; if ({lvl_b, pls_b} !== {el, ep}) begin errors++; $display("FAIL modes_fall t=%0d got %b/%b exp %b/%b", t, lvl_b, pls_b, el, ep); end
    end
  endtask

  task automatic test_filter;
    logic [3:0] el, ep;
    for (int len = 2; len <= 3; len++) begin
      sig_c = 4'b0001;
      for (int t = 1; t <= len; t++) begin
        tick();
        checks++; if ({lvl_c, pls_c} !== 8'h00) begin errors++; $display("FAIL glitch%0d_hi t=%0d got %b/%b exp 0000/0000", len, t, lvl_c, pls_c); end
      end
      sig_c = 4'b0000;
      for (int t = 1; t <= 10; t++) begin
        tick();
        checks++; if ({lvl_c, pls_c} !== 8'h00) begin errors++; $display("FAIL glitch%0d_lo t=%0d got %b/%b exp 0000/0000", len, t, lvl_c, pls_c); end
      end
    end
    sig_c = 4'b0001;
    for (int t = 1; t <= 9; t++) begin
      tick();
      el = (t >= 7) ? 4'b0001 : 4'b0000;
      ep = (t == 7) ? 4'b0001 : 4'b0000;
      checks++; if ({lvl_c, pls_c} !== {el, ep}) begin errors++; $display("FAIL filter_accept t=%0d got %b/%b exp %b/%b", t, lvl_c, pls_c, el, ep); end
    end
  endtask

  task automatic test_reset_val;
    logic [3:0] el, ep;
    sig_d = 4'b0101;
    for (int t = 1; t <= 4; t++) begin
      tick();
      el = (t >= 3) ? 4'b0101 : 4'b1010;
      ep = (t == 3) ? 4'b0101 : 4'b0000;
      checks++; if ({lvl_d, pls_d} !== {el, ep}) begin errors++; $display("FAIL resetval t=%0d got %b/%b exp %b/%b", t, lvl_d, pls_d, el, ep); end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] el, ep;
    sig_a = 4'b0111;
    tick();
    #3 rst = 1'b1;
    #1;
    checks++; if ({lvl_a, pls_a} !== 8'h00) begin errors++; $display("FAIL midrst_async got %b/%b exp 0000/0000", lvl_a, pls_a); end
    sig_a = 4'b0000;
    tick();
    tick();
    checks++; if ({lvl_a, pls_a} !== 8'h00) begin errors++; $display("FAIL midrst_held got %b/%b exp 0000/0000", lvl_a, pls_a); end
    rst = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++; if ({lvl_a, pls_a} !== 8'h00) begin errors++; $display("FAIL midrst_release t=%0d got %b/%b exp 0000/0000", t, lvl_a, pls_a); end
    end
    sig_a = 4'b0010;
    for (int t = 1; t <= 4; t++) begin
      tick();
      el = (t >= 3) ? 4'b0010 : 4'b0000;
      ep = (t == 3) ? 4'b0010 : 4'b0000;
      checks++; if ({lvl_a, pls_a} !== {el, ep}) begin errors++; $display("FAIL midrst_after t=%0d got %b/%b exp %b/%b", t, lvl_a, pls_a, el, ep); end
    end
  endtask

  task automatic test_random;
    logic [3:0] l1, p1, l2, p2, mask;
    int         odds;
    do_reset();
    l1 = 4'b0000;
    l2 = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      odds = (n < 1500) ? 3 : 9;
      for (int ch = 0; ch < 4; ch++) mask[ch] = ($urandom_range(0, odds) == 0);
      sig_r   = sig_r ^ mask;
      hist[n] = sig_r;
      tick();
      p1 = l1; l1 = next_lvl(n, 2, 1, l1);
      p2 = l2; l2 = next_lvl(n, 4, 3, l2);
      checks++;
      if ({lvl_r1, pls_r1} !== {l1, exp_pulse(l1, p1)}) begin
        errors++;
        $display("FAIL rand_s2f1 n=%0d got %b/%b exp %b/%b", n, lvl_r1, pls_r1, l1, exp_pulse(l1, p1));
      end
      checks++;
      if ({lvl_r2, pls_r2} !== {l2, exp_pulse(l2, p2)}) begin
        errors++;
        $display("FAIL rand_s4f3 n=%0d got %b/%b exp %b/%b", n, lvl_r2, pls_r2, l2, exp_pulse(l2, p2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge_modes();
    test_filter();
    test_reset_val();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
